// File: rtl/tcb_bist_man_if.sv
// TCB request/response bundle used by the memory BIST manager.
// The manager drives the request side, the memory under test answers.
interface tcb_bist_man_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned BW = DW/8
) ();

    logic          vld;
    logic          wen;
    logic [AW-1:0] adr;
    logic [BW-1:0] ben;
    logic [DW-1:0] wdt;
    logic          lck;
    logic          rpt;
    logic          rdy;
    logic [DW-1:0] rdt;
    logic          err;

    modport master (
        output vld, wen, adr, ben, wdt, lck, rpt,
        input  rdy, rdt, err
    );

    modport slave (
        input  vld, wen, adr, ben, wdt, lck, rpt,
        output rdy, rdt, err
    );

endinterface

// File: rtl/tcb_bist_man.sv
// Memory BIST manager: writes seed+i over a word range, reads it back,
// and counts failing responses (bus errors or read data mismatches).
module tcb_bist_man #(
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned SW  = 8,
    parameter int unsigned BW  = DW/SW,
    parameter int unsigned DLY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_str,
    input  logic [AW-1:0] cfg_adr,
    input  logic [AW-1:0] cfg_len,
    input  logic [DW-1:0] cfg_sed,
    output logic          sts_bsy,
    output logic          sts_dne,
    output logic          sts_fal,
    output logic [AW-1:0] sts_cnt,
    output logic [AW-1:0] sts_adr,
    tcb_bist_man_if.master tcb
);

    localparam int unsigned PD = (DLY > 0) ? DLY : 1;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        DRN
    } state_t;

    typedef struct packed {
        logic          vld;
        logic          wen;
        logic [DW-1:0] dat;
        logic [AW-1:0] adr;
    } ent_t;

    state_t        state;
    logic [AW-1:0] idx;
    logic [AW-1:0] base;
    logic [AW-1:0] len;
    logic [DW-1:0] seed;

    logic          vld_q;
    logic          wen_q;
    logic [AW-1:0] adr_q;
    logic [DW-1:0] wdt_q;

    ent_t          pipe [PD];
    ent_t          ent_new;
    ent_t          rsp;

    logic          trn;
    logic          last;
    logic          pend;
    logic          fail;
    logic [DW-1:0] exp_dat;

    assign tcb.vld = vld_q;
    assign tcb.wen = wen_q;
    assign tcb.adr = adr_q;
    assign tcb.wdt = wdt_q;
    assign tcb.ben = '1;
    assign tcb.lck = 1'b0;
    assign tcb.rpt = 1'b0;

    assign trn     = vld_q & tcb.rdy;
    assign last    = (idx == len - AW'(1));
    assign exp_dat = seed + DW'(idx);

    // With DLY=0 the response belongs to the transfer of this very cycle.
    always_comb begin
        ent_new = '{vld: trn, wen: wen_q, dat: exp_dat, adr: adr_q};
        rsp     = (DLY == 0) ? ent_new : pipe[PD-1];
        pend    = 1'b0;
        for (int k = 0; k + 1 < int'(PD); k++) begin
            pend = pend | pipe[k].vld;
        end
        fail = rsp.vld & (tcb.err | (~rsp.wen & (tcb.rdt != rsp.dat)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            base    <= '0;
            len     <= '0;
            seed    <= '0;
            vld_q   <= 1'b0;
            wen_q   <= 1'b0;
            adr_q   <= '0;
            wdt_q   <= '0;
            sts_bsy <= 1'b0;
            sts_dne <= 1'b0;
            sts_fal <= 1'b0;
            sts_cnt <= '0;
            sts_adr <= '0;
            for (int k = 0; k < int'(PD); k++) begin
                pipe[k] <= '0;
            end
        end else begin
            if (DLY > 0) begin
                pipe[0] <= ent_new;
            end else begin
                pipe[0] <= '0;
            end
            for (int k = 1; k < int'(PD); k++) begin
                pipe[k] <= pipe[k-1];
            end

            if (fail) begin
                sts_fal <= 1'b1;
                if (sts_cnt != '1) begin
                    sts_cnt <= sts_cnt + AW'(1);
                end
                if (!sts_fal) begin
                    sts_adr <= rsp.adr;
                end
            end

            unique case (state)
                IDLE: begin
                    if (cfg_str) begin
                        base    <= cfg_adr;
                        len     <= cfg_len;
                        seed    <= cfg_sed;
                        idx     <= '0;
                        adr_q   <= cfg_adr;
                        sts_bsy <= 1'b1;
                        sts_dne <= 1'b0;
                        sts_fal <= 1'b0;
                        sts_cnt <= '0;
                        sts_adr <= '0;
                        if (cfg_len == '0) begin
                            state <= DRN;
                        end else begin
                            state <= WR;
                            vld_q <= 1'b1;
                            wen_q <= 1'b1;
                            wdt_q <= cfg_sed;
                        end
                    end
                end
                WR: begin
                    if (trn) begin
                        if (last) begin
                            state <= RD;
                            idx   <= '0;
                            wen_q <= 1'b0;
                            wdt_q <= '0;
                            adr_q <= base;
                        end else begin
                            idx   <= idx + AW'(1);
                            adr_q <= adr_q + AW'(BW);
                            wdt_q <= wdt_q + DW'(1);
                        end
                    end
                end
                RD: begin
                    if (trn) begin
                        if (last) begin
                            state <= DRN;
                            vld_q <= 1'b0;
                        end else begin
                            idx   <= idx + AW'(1);
                            adr_q <= adr_q + AW'(BW);
                        end
                    end
                end
                DRN: begin
                    // The oldest entry retires this cycle; only younger ones keep us here.
                    if (!pend) begin
                        state   <= IDLE;
                        sts_bsy <= 1'b0;
                        sts_dne <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tcb_bist_man.sv
// Bench for tcb_bist_man: three instances (DLY 0/1/3) run the same
// stimulus against a delayed-response memory and a run-level model.
module tb_tcb_bist_man;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        rnd_rdy = 1'b0;
    logic        rdy = 1'b1;
    logic        cfg_str = 1'b0;
    logic [31:0] cfg_adr = '0;
    logic [31:0] cfg_len = '0;
    logic [31:0] cfg_sed = '0;
    logic [31:0] bad_adr = 32'h1;
    int          err_wr = 0;
    int          err_rd = 0;

    logic        bsy_a [NI];
    logic        dne_a [NI];
    logic        fal_a [NI];
    logic        vld_a [NI];
    logic        wen_a [NI];
    logic [31:0] cnt_a [NI];
    logic [31:0] sadr_a [NI];
    logic [31:0] badr_a [NI];
    logic [31:0] wdt_a [NI];
    int          wr_a [NI];
    int          rd_a [NI];
    int          bsyn_a [NI];
    int          chk_a [NI];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    always @(negedge clk) rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;

    function automatic int dly_of(input int g);
        return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int unsigned D  = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        localparam int unsigned DI = (D > 0) ? D - 1 : 0;

        tcb_bist_man_if #(.AW(32), .DW(32), .BW(4)) bus ();

        logic        bsy, dne, fal, t;
        logic [31:0] cnt, sadr;
        logic [31:0] mem [256];
        logic [32:0] now;
        logic [32:0] dl [4];
        int          wr_n = 0, rd_n = 0, bsy_n = 0, chk_n = 0;
        logic        pv = 1'b0, pr = 1'b0, pw = 1'b0, prst = 1'b1;
        logic [31:0] pa = '0, pd = '0;

        initial begin
            for (int k = 0; k < 4; k++) dl[k] = '0;
            for (int k = 0; k < 256; k++) mem[k] = '0;
        end

        tcb_bist_man #(
            .AW(32), .DW(32), .SW(8), .BW(4), .DLY(D)
        ) dut (
            .clk    (clk),
            .rst    (rst),
            .cfg_str(cfg_str),
            .cfg_adr(cfg_adr),
            .cfg_len(cfg_len),
            .cfg_sed(cfg_sed),
            .sts_bsy(bsy),
            .sts_dne(dne),
            .sts_fal(fal),
            .sts_cnt(cnt),
            .sts_adr(sadr),
            .tcb    (bus)
        );

        assign bus.rdy   = rdy;
        assign t         = bus.vld & rdy;
        assign bus.rdt   = (D == 0) ? now[31:0] : dl[DI][31:0];
        assign bus.err   = (D == 0) ? now[32] : dl[DI][32];
        assign bsy_a[g]  = bsy;
        assign dne_a[g]  = dne;
        assign fal_a[g]  = fal;
        assign cnt_a[g]  = cnt;
        assign sadr_a[g] = sadr;
        assign vld_a[g]  = bus.vld;
        assign wen_a[g]  = bus.wen;
        assign badr_a[g] = bus.adr;
        assign wdt_a[g]  = bus.wdt;
        assign wr_a[g]   = wr_n;
        assign rd_a[g]   = rd_n;
        assign bsyn_a[g] = bsy_n;
        assign chk_a[g]  = chk_n;

        always_comb begin
            now = '0;
            if (t) begin
                if (bus.wen) begin
                    now[32] = (wr_n + 1 == err_wr);
                end else begin
                    now[31:0] = mem[bus.adr[9:2]];
                    now[32]   = (rd_n + 1 == err_rd);
                end
            end
        end

        always @(posedge clk) begin
            dl[0] <= now;
            for (int k = 1; k < 4; k++) dl[k] <= dl[k-1];
            if (clr) begin
                wr_n  <= 0;
                rd_n  <= 0;
                bsy_n <= 0;
                chk_n <= 0;
            end else begin
                if (t && bus.wen) begin
                    mem[bus.adr[9:2]] <= (bus.adr == bad_adr) ? 32'hFF : bus.wdt;
                    wr_n <= wr_n + 1;
                end
                if (t && !bus.wen) rd_n <= rd_n + 1;
                if (bsy) bsy_n <= bsy_n + 1;
                chk_n <= chk_n
                    + int'(bus.vld && (bus.ben !== 4'hF || bus.lck !== 1'b0 ||
                                       bus.rpt !== 1'b0 ||
                                       (!bus.wen && bus.wdt !== 32'h0)))
                    + int'(pv && !pr && !prst &&
                           (bus.vld !== 1'b1 || bus.wen !== pw ||
                            bus.adr !== pa || bus.wdt !== pd));
            end
            pv   <= bus.vld;
            pr   <= rdy;
            pw   <= bus.wen;
            pa   <= bus.adr;
            pd   <= bus.wdt;
            prst <= rst;
        end
    end

    task automatic start(input logic [31:0] a, input logic [31:0] l,
                         input logic [31:0] s);
        @(negedge clk) clr = 1'b1;
        @(negedge clk);
        clr     = 1'b0;
        cfg_adr = a;
        cfg_len = l;
        cfg_sed = s;
        cfg_str = 1'b1;
        @(negedge clk) cfg_str = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!(dne_a[0] && dne_a[1] && dne_a[2]) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 3000) begin
            bad++;
            $display("FAIL %s timeout dne=%b%b%b want 111", nm,
                     dne_a[0], dne_a[1], dne_a[2]);
        end
    endtask

    // Expected status comes from walking the run: all writes, then all reads.
    task automatic check_run(input string nm, input logic [31:0] a,
                             input logic [31:0] l, input logic [31:0] s,
                             input logic rnd);
        int          nf, eb;
        logic [31:0] fa, ad, st, ex;
        nf = 0;
        fa = '0;
        for (int i = 0; i < int'(l); i++) begin
            if (err_wr == i + 1) begin
                if (nf == 0) fa = a + 32'(4 * i);
                nf++;
            end
        end
        for (int i = 0; i < int'(l); i++) begin
            ad = a + 32'(4 * i);
            ex = s + 32'(i);
            st = (ad == bad_adr) ? 32'hFF : ex;
            if (err_rd == i + 1 || st != ex) begin
                if (nf == 0) fa = ad;
                nf++;
            end
        end
        for (int g = 0; g < NI; g++) begin
            eb = (l == 0) ? 1 : 2 * int'(l) + ((dly_of(g) > 0) ? dly_of(g) : 1);
            total++;
            if (dne_a[g] !== 1'b1) begin
                bad++;
                $display("FAIL %s[%0d] dne got=%b want=1", nm, g, dne_a[g]);
            end
            total++;
            if (bsy_a[g] !== 1'b0) begin
                bad++;
                $display("FAIL %s[%0d] bsy got=%b want=0", nm, g, bsy_a[g]);
            end
            total++;
            if (fal_a[g] !== (nf > 0)) begin
                bad++;
                $display("FAIL %s[%0d] fal got=%b want=%b", nm, g, fal_a[g], nf > 0);
            end
            total++;
            if (cnt_a[g] !== 32'(nf)) begin
                bad++;
                $display("FAIL %s[%0d] cnt got=%0d want=%0d", nm, g, cnt_a[g], nf);
            end
            total++;
            if (sadr_a[g] !== fa) begin
                bad++;
                $display("FAIL %s[%0d] adr got=%h want=%h", nm, g, sadr_a[g], fa);
            end
            total++;
            if (wr_a[g] != int'(l) || rd_a[g] != int'(l)) begin
                bad++;
                $display("FAIL %s[%0d] trn wr=%0d rd=%0d want=%0d", nm, g,
                         wr_a[g], rd_a[g], l);
            end
            total++;
            if (chk_a[g] != 0) begin
                bad++;
                $display("FAIL %s[%0d] request rule breaks got=%0d want=0", nm, g,
                         chk_a[g]);
            end
            if (!rnd) begin
                total++;
                if (bsyn_a[g] != eb) begin
                    bad++;
                    $display("FAIL %s[%0d] busy cycles got=%0d want=%0d", nm, g,
                             bsyn_a[g], eb);
                end
            end
        end
    endtask

    task automatic check_idle(input string nm);
        for (int g = 0; g < NI; g++) begin
            total++;
            if (vld_a[g] !== 1'b0 || wen_a[g] !== 1'b0 ||
                badr_a[g] !== 32'h0 || wdt_a[g] !== 32'h0) begin
                bad++;
                $display("FAIL %s[%0d] req got vld=%b wen=%b adr=%h wdt=%h want 0",
                         nm, g, vld_a[g], wen_a[g], badr_a[g], wdt_a[g]);
            end
            total++;
            if (bsy_a[g] !== 1'b0 || dne_a[g] !== 1'b0 || fal_a[g] !== 1'b0 ||
                cnt_a[g] !== 32'h0 || sadr_a[g] !== 32'h0) begin
                bad++;
                $display("FAIL %s[%0d] sts got bsy=%b dne=%b fal=%b cnt=%0d adr=%h want 0",
                         nm, g, bsy_a[g], dne_a[g], fal_a[g], cnt_a[g], sadr_a[g]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
    endtask

    task automatic test_pass();
        logic [31:0] m;
        bad_adr = 32'h1;
        err_wr  = 0;
        err_rd  = 0;
        start(32'h100, 32'd4, 32'h10);
        wait_done("pass");
        check_run("pass", 32'h100, 32'd4, 32'h10, 1'b0);
        for (int i = 0; i < 4; i++) begin
            m = gi[1].mem[8'h40 + 8'(i)];
            total++;
            if (m !== 32'h10 + 32'(i)) begin
                bad++;
                $display("FAIL pass_wdata[%0d] got=%h want=%h", i, m, 32'h10 + 32'(i));
            end
        end
    endtask

    task automatic test_corrupt();
        bad_adr = 32'h108;
        start(32'h100, 32'd4, 32'h10);
        wait_done("corrupt");
        check_run("corrupt", 32'h100, 32'd4, 32'h10, 1'b0);
        bad_adr = 32'h1;
    endtask

    task automatic test_random_rdy();
        rnd_rdy = 1'b1;
        start(32'h100, 32'd4, 32'h10);
        wait_done("rnd_rdy");
        check_run("rnd_rdy", 32'h100, 32'd4, 32'h10, 1'b1);
        rnd_rdy = 1'b0;
    endtask

    task automatic test_err();
        logic [31:0] s;
        s      = $urandom;
        err_wr = 2;
        err_rd = 3;
        start(32'h2000, 32'd4, s);
        wait_done("err");
        check_run("err", 32'h2000, 32'd4, s, 1'b0);
        for (int g = 0; g < NI; g++) begin
            total++;
            if (cnt_a[g] !== 32'd2 || sadr_a[g] !== 32'h2004) begin
                bad++;
                $display("FAIL err_fixed[%0d] got cnt=%0d adr=%h want cnt=2 adr=2004",
                         g, cnt_a[g], sadr_a[g]);
            end
        end
        err_wr = 0;
        err_rd = 0;
    endtask

    task automatic test_len_zero();
        start(32'h600, 32'd0, 32'h5);
        wait_done("len0");
        check_run("len0", 32'h600, 32'd0, 32'h5, 1'b0);
    endtask

    task automatic test_ignore_str();
        start(32'h300, 32'd8, 32'hAB);
        repeat (3) @(negedge clk);
        cfg_adr = 32'h500;
        cfg_len = 32'd2;
        cfg_sed = 32'h77;
        cfg_str = 1'b1;
        @(negedge clk) cfg_str = 1'b0;
        wait_done("ign_str");
        check_run("ign_str", 32'h300, 32'd8, 32'hAB, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a, l, s;
        logic        r;
        for (int n = 0; n < 8; n++) begin
            a  = (n == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            l  = 32'($urandom_range(1, 20));
            s  = (n == 1) ? 32'hFFFF_FFFE : $urandom;
            r  = 1'($urandom_range(0, 1));
            bad_adr = $urandom_range(0, 1) ?
                      a + 32'(4 * $urandom_range(0, int'(l) - 1)) : 32'h1;
            err_wr  = $urandom_range(0, int'(l));
            err_rd  = $urandom_range(0, int'(l));
            rnd_rdy = r;
            start(a, l, s);
            wait_done("random");
            check_run("random", a, l, s, r);
        end
        rnd_rdy = 1'b0;
        bad_adr = 32'h1;
        err_wr  = 0;
        err_rd  = 0;
    endtask

    task automatic test_rst_mid();
        int n;
        err_rd = 2;
        start(32'h400, 32'd8, 32'h33);
        n = 0;
        while (rd_a[0] < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 200) begin
            bad++;
            $display("FAIL rst_mid timeout rd=%0d want>=3", rd_a[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < NI; g++) begin
            total++;
            if (vld_a[g] !== 1'b0 || bsy_a[g] !== 1'b0 || dne_a[g] !== 1'b0 ||
                fal_a[g] !== 1'b0 || cnt_a[g] !== 32'h0 || sadr_a[g] !== 32'h0) begin
                bad++;
                $display("FAIL rst_mid[%0d] got vld=%b bsy=%b dne=%b fal=%b cnt=%0d want 0",
                         g, vld_a[g], bsy_a[g], dne_a[g], fal_a[g], cnt_a[g]);
            end
        end
        repeat (6) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            total++;
            if (vld_a[g] !== 1'b0 || bsy_a[g] !== 1'b0 || dne_a[g] !== 1'b0 ||
                fal_a[g] !== 1'b0 || cnt_a[g] !== 32'h0 || sadr_a[g] !== 32'h0) begin
                bad++;
                $display("FAIL rst_late[%0d] got vld=%b bsy=%b dne=%b fal=%b cnt=%0d want 0",
                         g, vld_a[g], bsy_a[g], dne_a[g], fal_a[g], cnt_a[g]);
            end
        end
        err_rd = 0;
    endtask

    initial begin
        test_reset();
        test_pass();
        test_corrupt();
        test_random_rdy();
        test_err();
        test_len_zero();
        test_ignore_str();
        test_random();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tcb_bist_man.md
TCB_BIST_MAN -- requirements
Module: tcb_bist_man

Interface
REQ-001 Parameters SHALL be:
- AW, 32, address width
- DW, 32, data width
- SW, 8, selection width
- BW, DW/SW, byte enable width
- DLY, 1, response delay in cycles (0 allowed).
REQ-002 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- cfg_str  in  1  start pulse
- cfg_adr  in  AW  base byte address, BW-aligned
- cfg_len  in  AW  transfer count in words
- cfg_sed  in  DW  data seed
- sts_bsy  out  1  test in progress
- sts_dne  out  1  test finished, sticky
- sts_fal  out  1  at least one failure, sticky
- sts_cnt  out  AW  failure count
- sts_adr  out  AW  address of first failure
- tcb_vld  out  1  request valid
- tcb_wen  out  1  write enable
- tcb_adr  out  AW  address
- tcb_ben  out  BW  byte enable
- tcb_wdt  out  DW  write data
- tcb_lck  out  1  arbitration lock
- tcb_rpt  out  1  repeated access
- tcb_rdy  in  1  subordinate ready
- tcb_rdt  in  DW  read data
- tcb_err  in  1  bus error.

Function
REQ-003 A transfer SHALL occur in a cycle where tcb_vld & tcb_rdy is high (trn).
REQ-004 The response for a trn SHALL be sampled exactly DLY cycles after it; for DLY=0 it is sampled in the trn cycle.
REQ-005 The FSM SHALL have the states IDLE, WR, RD and DRN.
REQ-006 IDLE, cfg_str=1: capture cfg_*, clear sts_dne/sts_fal/sts_cnt/sts_adr, go to WR.
- If cfg_len=0, go directly to DRN instead.
REQ-007 cfg_str SHALL be ignored outside IDLE.
REQ-008 In WR, the block SHALL drive tcb_vld=1, tcb_wen=1, tcb_adr=base+i*BW, tcb_wdt=seed+i.
- i is the word index 0..len-1; the sum wraps modulo 2^DW.
- Address arithmetic wraps modulo 2^AW.
REQ-009 i SHALL advance only on trn.
- Request signals SHALL hold stable while tcb_vld=1 and tcb_rdy=0.
REQ-010 After the trn at i=len-1 in WR, the state SHALL go to RD with i=0 in the next cycle, without an idle cycle.
REQ-011 In RD, the block SHALL drive tcb_vld=1, tcb_wen=0, with the same address and index sequence as WR.
- After the last trn, go to DRN.
REQ-012 tcb_ben SHALL be all ones, tcb_lck=0 and tcb_rpt=0 at all times.
REQ-013 tcb_wdt SHALL be 0 while tcb_wen=0.
REQ-014 In-flight tracking SHALL use a DLY-deep shift register carrying {valid, wen, expected data, address} per trn.
- This supports a trn every cycle.
REQ-015 A response SHALL be a failure if tcb_err=1, or if it is a read and tcb_rdt != seed+i.
REQ-016 On each failure:
- sts_fal SHALL be set.
- sts_cnt SHALL increment, saturating at 2^AW-1.
- sts_adr SHALL be loaded only on the first failure of a run.
REQ-017 DRN SHALL go to IDLE once no responses are outstanding.
- On that transition sts_dne=1; sts_dne stays 1 until the next accepted cfg_str.
- With DLY=0, DRN lasts exactly 1 cycle.
REQ-018 sts_bsy SHALL be 1 in WR, RD and DRN, and 0 in IDLE.
REQ-019 tcb_vld SHALL be 0 in IDLE and DRN.
REQ-020 Request outputs SHALL be registered, with no combinational path from tcb_rdy to any output.

Reset
REQ-021 While rst=1, at the next clk edge:
- state=IDLE, i=0, shift register cleared.
- tcb_vld, tcb_wen, tcb_adr, tcb_wdt = 0.
- sts_* = 0.
REQ-022 Reset mid-run SHALL abort the run.
- Responses to in-flight transfers SHALL be discarded.
- No status update SHALL occur after reset.

Verification
REQ-023 DLY=1, rdy always 1, adr=0x100, len=4, seed=0x10, ideal memory:
- writes 0x100..0x10C with data 0x10..0x13, then 4 reads.
- sts_dne=1, sts_fal=0 after 9 cycles of busy.
REQ-024 Same setup, memory corrupts word 0x108 to 0xFF:
- sts_fal=1, sts_cnt=1, sts_adr=0x108.
REQ-025 rdy toggled pseudo-randomly 50%:
- request signals stable during stall, every trn counted once.
- pass result identical to REQ-023.
REQ-026 DLY=0 and DLY=3, tcb_err=1 on the 2nd write and the 3rd read, len=4:
- sts_cnt=2, sts_adr=base+4.
REQ-027 len=0:
- no trn, sts_dne=1 after DRN.
- cfg_str during busy is ignored.
REQ-028 rst asserted during RD with responses outstanding:
- next cycle tcb_vld=0, sts_*=0.
- late responses cause no status change.
